jmp_br_jalr_ctrl: RTL and testbench
===================================

JMP_BR_JALR_CTRL -- requirements
Module: jmp_br_jalr_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter BUBBLE_CYCLES, default 1 (legal 1..7): fetch-invalid cycles after each accepted redirect.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_br_jmp_valid  input  1  branch/jump unit requests a redirect.
REQ-006 io_br_jmp  input  32  branch/jump target.
REQ-007 io_jalr_valid  input  1  JALR unit requests a redirect.
REQ-008 io_jalr  input  32  JALR target (unmasked).
REQ-009 io_stall  input  1  pipeline stall; freezes sequential PC advance.
REQ-010 io_fetch_ready  input  1  fetch stage accepts io_pc this cycle.
REQ-011 io_pc  output  32  current fetch PC.
REQ-012 io_pc_valid  output  1  io_pc is a valid fetch request.
REQ-013 io_jmp_br_jalr_mux_sel  output  1  target-mux select: 1 = JALR, 0 = branch/jump.
REQ-014 io_flush  output  1  kill younger in-flight instructions; asserted in the redirect-accept cycle.
REQ-015 io_misaligned  output  1  one-cycle pulse: a redirect was rejected for misalignment.
REQ-016 io_redirect_cnt  output  8  count of accepted redirects.

Function
REQ-017 The block SHALL have two states: RUN and BUBBLE.
REQ-018 io_pc_valid SHALL be 1 in RUN and 0 in BUBBLE.
REQ-019 In RUN, with no redirect accepted, io_pc_valid & io_fetch_ready & !io_stall SHALL load io_pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC -> 0); otherwise io_pc SHALL hold.
REQ-020 Selection is combinational: io_jalr_valid -> sel=1, target = {io_jalr[31:1],1'b0}; else sel=0, target = io_br_jmp.
REQ-021 When neither request is valid, sel SHALL be 0.
REQ-022 A redirect SHALL be accepted in any state when a request is valid and target[1:0]==2'b00, regardless of io_stall and io_fetch_ready.
REQ-023 If target[1:0]!=2'b00, the redirect SHALL be rejected: io_misaligned=1 in the same cycle, io_flush=0, and PC/state/counter unchanged.
REQ-024 On accept: io_flush=1 combinationally in the same cycle.
REQ-025 On accept, at the next edge: io_pc <= target, state <= BUBBLE, bubble counter <= BUBBLE_CYCLES-1, io_redirect_cnt +1 (wraps 255 -> 0).
REQ-026 In BUBBLE with no redirect, the counter SHALL decrement each cycle, and state SHALL go to RUN on the edge where the counter is 0.
REQ-027 A redirect accepted during BUBBLE SHALL overwrite io_pc and restart the counter per REQ-025.
REQ-028 io_pc SHALL never advance while in BUBBLE.

Reset
REQ-029 Reset SHALL set: io_pc=RESET_VECTOR, state=RUN, bubble counter=0, io_redirect_cnt=0.
REQ-030 While reset is high, io_pc_valid, io_flush and io_misaligned SHALL be 0.
REQ-031 Reset SHALL override any simultaneous redirect, including during BUBBLE.

Structure
REQ-032 State encoding (RUN=0, BUBBLE=1) and the PC increment constant 4 SHALL live in the shared core constants package.
REQ-033 Target selection SHALL instantiate the existing jmp_br_jalr_mux as the single sub-module; its select input SHALL be driven by io_jmp_br_jalr_mux_sel.

Verification
REQ-034 Reset release, fetch_ready=1: io_pc = 0x0, 0x4, 0x8 on successive cycles, io_pc_valid=1 from the first post-reset cycle.
REQ-035 Both requests valid in the same cycle, jalr=0x1001, br_jmp=0x2000: sel=1, flush=1 that cycle; io_pc=0x1000 next cycle with pc_valid=0; pc_valid=1 one cycle later; cnt=1.
REQ-036 br_jmp=0x3002 valid: io_misaligned=1, flush=0, io_pc unchanged, cnt unchanged.
REQ-037 BUBBLE_CYCLES=3: redirect to 0x400, then a second redirect to 0x800 in bubble cycle 2: io_pc=0x800, three further invalid cycles, then RUN.
REQ-038 io_stall=1 with a br_jmp redirect to 0x40: redirect accepted, io_pc=0x40; PC then holds while stall=1.
REQ-039 PC=0xFFFF_FFFC, fetch_ready=1: next io_pc=0x0. Also: 256 redirects -> cnt wraps to 0.

Source files
------------

// File: rtl/jmp_br_jalr_ctrl_pkg.sv
// Shared core constants for the fetch-redirect controller: state encoding,
// PC step and small address helpers.
package jmp_br_jalr_ctrl_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } ctrl_state_e;

  localparam addr_t       PC_INC       = 32'd4;
  localparam int unsigned BUBBLE_CNT_W = 3;

  function automatic logic is_word_aligned(input addr_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/jmp_br_jalr_ctrl_if.sv
// Redirect request / fetch handshake bundle between the execute-side units,
// the fetch stage and the PC controller.
interface jmp_br_jalr_ctrl_if;
  import jmp_br_jalr_ctrl_pkg::*;

  logic       io_br_jmp_valid;
  addr_t      io_br_jmp;
  logic       io_jalr_valid;
  addr_t      io_jalr;
  logic       io_stall;
  logic       io_fetch_ready;
  addr_t      io_pc;
  logic       io_pc_valid;
  logic       io_jmp_br_jalr_mux_sel;
  logic       io_flush;
  logic       io_misaligned;
  logic [7:0] io_redirect_cnt;

  modport master (
    output io_br_jmp_valid, io_br_jmp, io_jalr_valid, io_jalr,
           io_stall, io_fetch_ready,
    input  io_pc, io_pc_valid, io_jmp_br_jalr_mux_sel, io_flush,
           io_misaligned, io_redirect_cnt
  );

  modport slave (
    input  io_br_jmp_valid, io_br_jmp, io_jalr_valid, io_jalr,
           io_stall, io_fetch_ready,
    output io_pc, io_pc_valid, io_jmp_br_jalr_mux_sel, io_flush,
           io_misaligned, io_redirect_cnt
  );

endinterface

// File: rtl/jmp_br_jalr_mux.sv
// Redirect target mux: JALR targets have bit 0 cleared, branch/jump targets
// pass through untouched.
module jmp_br_jalr_mux
  import jmp_br_jalr_ctrl_pkg::*;
(
  input  logic  sel,
  input  addr_t jalr,
  input  addr_t br_jmp,
  output addr_t target
);

  assign target = sel ? {jalr[31:1], 1'b0} : br_jmp;

endmodule

// File: rtl/jmp_br_jalr_ctrl.sv
// Fetch PC controller: sequential PC advance, redirect accept/reject with
// misalignment detection, and a fixed-length fetch bubble after each redirect.
module jmp_br_jalr_ctrl
  import jmp_br_jalr_ctrl_pkg::*;
#(
  parameter addr_t       RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned BUBBLE_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  jmp_br_jalr_ctrl_if.slave io
);

  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_RELOAD = BUBBLE_CNT_W'(BUBBLE_CYCLES - 1);

  ctrl_state_e             state_q, state_d;
  addr_t                   pc_q, pc_d;
  logic [BUBBLE_CNT_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]              cnt_q, cnt_d;

  addr_t target;
  logic  req;
  logic  accept;
  logic  reject;

  assign io.io_jmp_br_jalr_mux_sel = io.io_jalr_valid;

  jmp_br_jalr_mux u_mux (
    .sel    (io.io_jmp_br_jalr_mux_sel),
    .jalr   (io.io_jalr),
    .br_jmp (io.io_br_jmp),
    .target (target)
  );

  // Redirect decision and next-state / next-PC computation
  always_comb begin
    req     = io.io_jalr_valid | io.io_br_jmp_valid;
    accept  = req & is_word_aligned(target);
    reject  = req & ~is_word_aligned(target);
    state_d = state_q;
    pc_d    = pc_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;

    if (accept) begin
      pc_d    = target;
      state_d = ST_BUBBLE;
      bcnt_d  = BUBBLE_RELOAD;
      cnt_d   = cnt_q + 8'd1;
    end else if (reject) begin
      // A rejected redirect freezes the whole controller for that cycle.
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (io.io_fetch_ready && !io.io_stall) begin
            pc_d = pc_q + PC_INC;
          end else begin
            pc_d = pc_q;
          end
        end
        ST_BUBBLE: begin
          if (bcnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            bcnt_d = bcnt_q - BUBBLE_CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, PC and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      bcnt_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.io_pc           = pc_q;
  assign io.io_pc_valid     = ~reset & (state_q == ST_RUN);
  assign io.io_flush        = ~reset & accept;
  assign io.io_misaligned   = ~reset & reject;
  assign io.io_redirect_cnt = cnt_q;

endmodule

// File: tb/tb_jmp_br_jalr_ctrl.sv
// Directed bench for jmp_br_jalr_ctrl: two instances (1 and 3 bubble cycles)
// checked every cycle against a behavioural model plus literal expectations.
module tb_jmp_br_jalr_ctrl;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        bv    = 1'b0;
  logic [31:0] br    = 32'd0;
  logic        jv    = 1'b0;
  logic [31:0] jalr  = 32'd0;
  logic        stall = 1'b0;
  logic        ready = 1'b1;
  logic        chk_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  jmp_br_jalr_ctrl_if if_a ();
  jmp_br_jalr_ctrl_if if_b ();

  assign if_a.io_br_jmp_valid = bv;
  assign if_a.io_br_jmp       = br;
  assign if_a.io_jalr_valid   = jv;
  assign if_a.io_jalr         = jalr;
  assign if_a.io_stall        = stall;
  assign if_a.io_fetch_ready  = ready;
  assign if_b.io_br_jmp_valid = bv;
  assign if_b.io_br_jmp       = br;
  assign if_b.io_jalr_valid   = jv;
  assign if_b.io_jalr         = jalr;
  assign if_b.io_stall        = stall;
  assign if_b.io_fetch_ready  = ready;

  jmp_br_jalr_ctrl #(.RESET_VECTOR(32'h0000_0000), .BUBBLE_CYCLES(1)) dut_a (
    .clock (clock), .reset (rst), .io (if_a));
  jmp_br_jalr_ctrl #(.RESET_VECTOR(32'h0000_0000), .BUBBLE_CYCLES(3)) dut_b (
    .clock (clock), .reset (rst), .io (if_b));

  always #5 clock = ~clock;

  logic [31:0] o_pc    [2];
  logic        o_valid [2];
  logic        o_sel   [2];
  logic        o_flush [2];
  logic        o_mis   [2];
  logic [7:0]  o_cnt   [2];

  assign o_pc[0]    = if_a.io_pc;
  assign o_pc[1]    = if_b.io_pc;
  assign o_valid[0] = if_a.io_pc_valid;
  assign o_valid[1] = if_b.io_pc_valid;
  assign o_sel[0]   = if_a.io_jmp_br_jalr_mux_sel;
  assign o_sel[1]   = if_b.io_jmp_br_jalr_mux_sel;
  assign o_flush[0] = if_a.io_flush;
  assign o_flush[1] = if_b.io_flush;
  assign o_mis[0]   = if_a.io_misaligned;
  assign o_mis[1]   = if_b.io_misaligned;
  assign o_cnt[0]   = if_a.io_redirect_cnt;
  assign o_cnt[1]   = if_b.io_redirect_cnt;

  task automatic chk(input int inst, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: PC, invalid fetch cycles still to come, and redirect count.
  logic [31:0] m_pc   [2] = '{32'd0, 32'd0};
  int          m_left [2] = '{0, 0};
  logic [7:0]  m_cnt  [2] = '{8'd0, 8'd0};
  int          bc     [2] = '{1, 3};
  logic [31:0] m_tgt;
  logic        m_req;
  logic        m_ok;

  initial begin
    forever begin
      @(negedge clock);
      m_req = jv | bv;
      m_tgt = jv ? (jalr & ~32'd1) : br;
      m_ok  = (m_tgt % 4) == 0;
      for (int k = 0; k < 2; k++) begin
        if (chk_en) begin
          chk(k, "pc",    o_pc[k],    m_pc[k]);
          chk(k, "valid", o_valid[k], !rst && (m_left[k] == 0));
          chk(k, "sel",   o_sel[k],   jv);
          chk(k, "flush", o_flush[k], !rst && m_req && m_ok);
          chk(k, "mis",   o_mis[k],   !rst && m_req && !m_ok);
          chk(k, "cnt",   o_cnt[k],   m_cnt[k]);
        end
        if (rst) begin
          m_pc[k] = 32'd0; m_left[k] = 0; m_cnt[k] = 8'd0;
        end else if (m_req && m_ok) begin
          m_pc[k] = m_tgt; m_left[k] = bc[k]; m_cnt[k] = m_cnt[k] + 8'd1;
        end else if (!m_req) begin
          if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
          else if (ready && !stall) m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  end

  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk(0, "lit_pc0", o_pc[0], 32'h0);
    chk(0, "lit_valid0", o_valid[0], 1'b1);
    step(); chk(0, "lit_pc4", o_pc[0], 32'h4);
    step(); chk(0, "lit_pc8", o_pc[0], 32'h8);

    // Simultaneous requests: JALR wins and bit 0 is masked.
    jv = 1'b1; jalr = 32'h1001; bv = 1'b1; br = 32'h2000;
    #1;
    chk(0, "lit_sel_both", o_sel[0], 1'b1);
    chk(0, "lit_flush_both", o_flush[0], 1'b1);
    step(); jv = 1'b0; bv = 1'b0; #1;
    chk(0, "lit_pc_jalr", o_pc[0], 32'h1000);
    chk(0, "lit_bubble_a", o_valid[0], 1'b0);
    chk(1, "lit_pc_jalr", o_pc[1], 32'h1000);
    step();
    chk(0, "lit_run_a", o_valid[0], 1'b1);
    chk(0, "lit_pc_hold", o_pc[0], 32'h1000);
    chk(0, "lit_cnt1", o_cnt[0], 8'd1);
    step(); step();

    // Misaligned branch target is rejected.
    bv = 1'b1; br = 32'h3002;
    #1;
    chk(0, "lit_mis", o_mis[0], 1'b1);
    chk(0, "lit_mis_noflush", o_flush[0], 1'b0);
    step(); bv = 1'b0; #1;
    chk(0, "lit_mis_pc", o_pc[0], 32'h1008);
    chk(0, "lit_mis_cnt", o_cnt[0], 8'd1);

    // Three-cycle bubble restarted by a second redirect.
    bv = 1'b1; br = 32'h400;
    step(); bv = 1'b0; #1;
    chk(1, "lit_b_pc400", o_pc[1], 32'h400);
    chk(1, "lit_b_bub1", o_valid[1], 1'b0);
    step();
    bv = 1'b1; br = 32'h800;
    step(); bv = 1'b0; #1;
    chk(1, "lit_b_pc800", o_pc[1], 32'h800);
    chk(1, "lit_b_inv1", o_valid[1], 1'b0);
    step(); chk(1, "lit_b_inv2", o_valid[1], 1'b0);
    step(); chk(1, "lit_b_inv3", o_valid[1], 1'b0);
    step();
    chk(1, "lit_b_run", o_valid[1], 1'b1);
    chk(1, "lit_b_run_pc", o_pc[1], 32'h800);

    // Redirect accepted under stall; PC then holds.
    stall = 1'b1; bv = 1'b1; br = 32'h40;
    #1;
    chk(0, "lit_stall_flush", o_flush[0], 1'b1);
    step(); bv = 1'b0; #1;
    chk(0, "lit_stall_pc", o_pc[0], 32'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk(0, "lit_stall_hold", o_pc[0], 32'h40);
      chk(1, "lit_stall_hold", o_pc[1], 32'h40);
    end
    stall = 1'b0;

    // PC wrap at the top of the address space.
    bv = 1'b1; br = 32'hFFFF_FFFC;
    step(); bv = 1'b0;
    step();
    chk(0, "lit_top_pc", o_pc[0], 32'hFFFF_FFFC);
    chk(0, "lit_top_valid", o_valid[0], 1'b1);
    step();
    chk(0, "lit_wrap_pc", o_pc[0], 32'h0);
    step(); step();

    // JALR target misaligned even after bit-0 masking.
    jv = 1'b1; jalr = 32'h1003;
    #1;
    chk(0, "lit_jalr_mis", o_mis[0], 1'b1);
    chk(0, "lit_jalr_sel", o_sel[0], 1'b1);
    step(); jv = 1'b0;
    step();

    // Reset during a bubble overrides a concurrent redirect.
    bv = 1'b1; br = 32'h500;
    step();
    br = 32'h600; rst = 1'b1;
    #1;
    chk(0, "lit_rst_valid", o_valid[0], 1'b0);
    chk(0, "lit_rst_flush", o_flush[0], 1'b0);
    chk(0, "lit_rst_mis", o_mis[0], 1'b0);
    step(); rst = 1'b0; bv = 1'b0; #1;
    chk(0, "lit_rst_pc", o_pc[0], 32'h0);
    chk(0, "lit_rst_cnt", o_cnt[0], 8'd0);
    chk(1, "lit_rst_cnt", o_cnt[1], 8'd0);
    step();

    // 256 back-to-back redirects wrap the counter.
    for (int i = 0; i < 256; i++) begin
      jv = 1'b1;
      jalr = 32'h100 + 32'(i) * 32'd4 + 32'(i % 2);
      step();
    end
    jv = 1'b0;
    #1;
    chk(0, "lit_cnt_wrap", o_cnt[0], 8'd0);
    chk(1, "lit_cnt_wrap", o_cnt[1], 8'd0);
    chk(0, "lit_last_pc", o_pc[0], 32'h4FC);
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
